// File: rtl/exec_operand_stage.sv
// Operand-fetch stage: resolves rs1/rs2 against EX/WB producers, detects hazards, registers ALU operands.
// Optional build macro EXEC_OPERAND_FWD_EN enables EX/WB forwarding; undefined, any producer match stalls.
module exec_operand_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [4:0]  RS1_ADDR,
  input  logic [4:0]  RS2_ADDR,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  input  logic [31:0] IMM,
  input  logic [31:0] PC,
  input  logic        SRCA_SEL,
  input  logic        SRCB_SEL,
  input  logic [3:0]  ALU_FUN_IN,
  input  logic [4:0]  RD_IN,
  input  logic        REGWR_IN,
  input  logic        MEMRD_IN,
  input  logic        EX_WE,
  input  logic [4:0]  EX_RD,
  input  logic [31:0] EX_DATA,
  input  logic        EX_IS_LOAD,
  input  logic        WB_WE,
  input  logic [4:0]  WB_RD,
  input  logic [31:0] WB_DATA,
  input  logic        FLUSH,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ALU_FUN,
  output logic [4:0]  RD,
  output logic        REGWR,
  output logic        MEMRD,
  output logic [31:0] STORE_DATA,
  output logic [15:0] STALL_CNT
);

  logic        ex_m1, ex_m2, wb_m1, wb_m2;
  logic        hazard;
  logic        take;
  logic [31:0] rs1_res, rs2_res;

  // x0 is hardwired zero, so a nonzero source address is required for any match.
  always_comb begin
    ex_m1 = EX_WE && (RS1_ADDR != '0) && (EX_RD == RS1_ADDR);
    ex_m2 = EX_WE && (RS2_ADDR != '0) && (EX_RD == RS2_ADDR);
    wb_m1 = WB_WE && (RS1_ADDR != '0) && (WB_RD == RS1_ADDR);
    wb_m2 = WB_WE && (RS2_ADDR != '0) && (WB_RD == RS2_ADDR);
  end

`ifdef EXEC_OPERAND_FWD_EN
  always_comb begin
    rs1_res = RS1_DATA;
    rs2_res = RS2_DATA;
    if (ex_m1 && !EX_IS_LOAD) rs1_res = EX_DATA;
    else if (wb_m1)           rs1_res = WB_DATA;
    if (ex_m2 && !EX_IS_LOAD) rs2_res = EX_DATA;
    else if (wb_m2)           rs2_res = WB_DATA;
    hazard = IN_VALID && EX_IS_LOAD && (ex_m1 || ex_m2);
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{EX_DATA, WB_DATA, EX_IS_LOAD};

  always_comb begin
    rs1_res = RS1_DATA;
    rs2_res = RS2_DATA;
    hazard  = IN_VALID && (ex_m1 || ex_m2 || wb_m1 || wb_m2);
  end
`endif

  assign IN_READY = !RST && (!OUT_VALID || OUT_READY) && !hazard && !FLUSH;
  assign take     = IN_VALID && IN_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID  <= 1'b0;
      A          <= '0;
      B          <= '0;
      ALU_FUN    <= '0;
      RD         <= '0;
      REGWR      <= 1'b0;
      MEMRD      <= 1'b0;
      STORE_DATA <= '0;
      STALL_CNT  <= '0;
    end else begin
      if (hazard && (STALL_CNT != '1))
        STALL_CNT <= STALL_CNT + 16'd1;
      // take already excludes FLUSH; flush still wins over a pending drain.
      if (FLUSH) begin
        OUT_VALID <= 1'b0;
      end else if (take) begin
        OUT_VALID  <= 1'b1;
        A          <= SRCA_SEL ? PC  : rs1_res;
        B          <= SRCB_SEL ? IMM : rs2_res;
        ALU_FUN    <= ALU_FUN_IN;
        RD         <= RD_IN;
        REGWR      <= REGWR_IN;
        MEMRD      <= MEMRD_IN;
        STORE_DATA <= rs2_res;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule
